// File: rtl/record_sequencer.sv
// Recording session sequencer: eighth-note tick, record enable, length tracking and playback.
// Define COUNT_IN_EN to add a count-in phase (with click pulses) ahead of recording.
module record_sequencer #(
    parameter int SLOTS          = 160,
    parameter int DEFAULT_PERIOD = 34816000,
    parameter int COUNT_IN_TICKS = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  btn_record_in,
    input  logic                  btn_play_in,
    input  logic [25:0]           tick_period_in,
    input  logic [SLOTS-1:0][5:0] notes_in,
    output logic                  record_active_out,
    output logic                  tick_out,
    output logic [7:0]            slot_idx_out,
    output logic [7:0]            recorded_len_out,
    output logic [5:0]            play_note_out,
    output logic                  play_valid_out,
    output logic                  click_out,
    output logic [2:0]            state_out
);

    // state      | meaning
    // IDLE       | no session, waiting for a button
    // COUNT_IN   | clicking the count-in before recording
    // RECORD     | writer enabled, one slot per tick
    // DONE       | session captured, waiting for a button
    // PLAYBACK   | stepping through the captured slots
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COUNT_IN = 3'd1,
        S_RECORD   = 3'd2,
        S_DONE     = 3'd3,
        S_PLAYBACK = 3'd4
    } state_t;

    if (SLOTS < 1 || SLOTS > 255 || COUNT_IN_TICKS < 1 || COUNT_IN_TICKS > 255) begin : g_param_check
        $error("record_sequencer: SLOTS and COUNT_IN_TICKS must be in 1..255");
    end

    localparam logic [25:0] DEF_P   = 26'(DEFAULT_PERIOD);
    localparam logic [7:0]  SLOTS_B = 8'(SLOTS);

    state_t      state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic [25:0] period_q, period_d;
    logic [25:0] sel_period;
    logic [7:0]  slot_q, slot_d;
    logic [7:0]  len_q, len_d;
    logic [5:0]  note_q;
    logic        ticking, tick;
    logic        start_rec, start_play;

`ifdef COUNT_IN_EN
    localparam state_t     START_STATE = S_COUNT_IN;
    localparam logic [7:0] CI_LAST     = 8'(COUNT_IN_TICKS - 1);
    logic [7:0] ci_q, ci_d;
`else
    localparam state_t START_STATE = S_RECORD;
`endif

    assign ticking    = state_q inside {S_COUNT_IN, S_RECORD, S_PLAYBACK};
    assign tick       = ticking && (cnt_q == period_q - 26'd1);
    assign sel_period = (tick_period_in == 26'd0) ? DEF_P : tick_period_in;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        slot_d     = slot_q;
        len_d      = len_q;
        start_rec  = 1'b0;
        start_play = 1'b0;
`ifdef COUNT_IN_EN
        ci_d       = ci_q;
`endif
        if (ticking) begin
            cnt_d = tick ? 26'd0 : cnt_q + 26'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (btn_record_in) begin
                    start_rec = 1'b1;
                end else if (btn_play_in && len_q != 8'd0) begin
                    start_play = 1'b1;
                end
            end
`ifdef COUNT_IN_EN
            S_COUNT_IN: begin
                if (btn_record_in) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    ci_d = ci_q + 8'd1;
                    // counter wraps on this tick, so RECORD keeps the same tick grid
                    if (ci_q == CI_LAST) begin
                        state_d = S_RECORD;
                        slot_d  = 8'd0;
                    end
                end
            end
`endif
            S_RECORD: begin
                if (btn_record_in) begin
                    state_d = S_DONE;
                    len_d   = slot_q;
                end else if (tick) begin
                    slot_d = slot_q + 8'd1;
                    if (slot_q == SLOTS_B - 8'd1) begin
                        state_d = S_DONE;
                        len_d   = SLOTS_B;
                    end
                end
            end
            S_PLAYBACK: begin
                if (btn_record_in) begin
                    start_rec = 1'b1;
                end else if (btn_play_in) begin
                    state_d = S_DONE;
                end else if (tick) begin
                    if (slot_q == len_q - 8'd1) begin
                        state_d = S_DONE;
                    end else begin
                        slot_d = slot_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_rec) begin
            state_d  = START_STATE;
            cnt_d    = 26'd0;
            slot_d   = 8'd0;
            period_d = sel_period;
`ifdef COUNT_IN_EN
            ci_d     = 8'd0;
`endif
        end
        if (start_play) begin
            state_d  = S_PLAYBACK;
            cnt_d    = 26'd0;
            slot_d   = 8'd0;
            period_d = sel_period;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= 26'd0;
            period_q <= 26'd0;
            slot_q   <= 8'd0;
            len_q    <= 8'd0;
            note_q   <= 6'd0;
`ifdef COUNT_IN_EN
            ci_q     <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            slot_q   <= slot_d;
            len_q    <= len_d;
            // slot stays below SLOTS in PLAYBACK; the compare keeps the index in range regardless
            if (state_q == S_PLAYBACK && slot_q < SLOTS_B) begin
                note_q <= notes_in[slot_q];
            end else begin
                note_q <= 6'd0;
            end
`ifdef COUNT_IN_EN
            ci_q     <= ci_d;
`endif
        end
    end

    assign record_active_out = (state_q == S_RECORD);
    assign play_valid_out    = (state_q == S_PLAYBACK);
    assign play_note_out     = (state_q == S_PLAYBACK) ? note_q : 6'd0;
    assign tick_out          = tick;
    assign slot_idx_out      = slot_q;
    assign recorded_len_out  = len_q;
    assign state_out         = state_q;
`ifdef COUNT_IN_EN
    assign click_out         = (state_q == S_COUNT_IN) && tick;
`else
    assign click_out         = 1'b0;
`endif

endmodule

// File: tb/tb_record_sequencer.sv
// Self-checking bench for record_sequencer: vector table, hand sequences and a random run against a timing model.
module tb_record_sequencer;

    localparam int SLOTS   = 160;
    localparam int DEF_P   = 20;
    localparam int CI_TKS  = 8;
`ifdef COUNT_IN_EN
    localparam bit CI_EN   = 1'b1;
`else
    localparam bit CI_EN   = 1'b0;
`endif

    logic                  clk_in = 1'b0;
    logic                  rst_n_in = 1'b0;
    logic                  btn_record_in = 1'b0;
    logic                  btn_play_in = 1'b0;
    logic [25:0]           tick_period_in = 26'd4;
    logic [SLOTS-1:0][5:0] notes_in;
    logic                  record_active_out;
    logic                  tick_out;
    logic [7:0]            slot_idx_out;
    logic [7:0]            recorded_len_out;
    logic [5:0]            play_note_out;
    logic                  play_valid_out;
    logic                  click_out;
    logic [2:0]            state_out;

    int checks = 0;
    int errors = 0;

    // behavioural model: session time in cycles, slot = elapsed ticks
    int m_mode, m_phase, m_per, m_len, m_prev_mode, m_prev_slot;

    record_sequencer #(
        .SLOTS(SLOTS),
        .DEFAULT_PERIOD(DEF_P),
        .COUNT_IN_TICKS(CI_TKS)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .btn_record_in(btn_record_in),
        .btn_play_in(btn_play_in),
        .tick_period_in(tick_period_in),
        .notes_in(notes_in),
        .record_active_out(record_active_out),
        .tick_out(tick_out),
        .slot_idx_out(slot_idx_out),
        .recorded_len_out(recorded_len_out),
        .play_note_out(play_note_out),
        .play_valid_out(play_valid_out),
        .click_out(click_out),
        .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_per = 0; m_len = 0; m_prev_mode = 0; m_prev_slot = 0;
    endtask

    function automatic bit model_tick();
        if (!(m_mode == 1 || m_mode == 2 || m_mode == 4) || m_per == 0) return 1'b0;
        return (m_phase % m_per) == (m_per - 1);
    endfunction

    function automatic int model_slot();
        return (m_per > 0) ? m_phase / m_per : 0;
    endfunction

    task automatic model_step(input bit rec, input bit play, input int p_in);
        bit t;
        int s;
        bit start_rec, start_pb;
        t = model_tick();
        s = model_slot();
        m_prev_mode = m_mode;
        m_prev_slot = s;
        start_rec = 1'b0;
        start_pb  = 1'b0;
        case (m_mode)
            0, 3: begin
                if (rec) start_rec = 1'b1;
                else if (play && m_len > 0) start_pb = 1'b1;
            end
            1: begin
                if (rec) m_mode = 0;
                else if (t && s + 1 == CI_TKS) begin m_mode = 2; m_phase = 0; end
                else m_phase++;
            end
            2: begin
                if (rec) begin m_mode = 3; m_len = s; end
                else if (t && s + 1 == SLOTS) begin m_mode = 3; m_len = SLOTS; end
                else m_phase++;
            end
            4: begin
                if (rec) start_rec = 1'b1;
                else if (play) m_mode = 3;
                else if (t && s == m_len - 1) m_mode = 3;
                else m_phase++;
            end
            default: m_mode = 0;
        endcase
        if (start_rec) begin
            m_mode = CI_EN ? 1 : 2;
            m_phase = 0;
            m_per = (p_in == 0) ? DEF_P : p_in;
        end
        if (start_pb) begin
            m_mode = 4;
            m_phase = 0;
            m_per = (p_in == 0) ? DEF_P : p_in;
        end
    endtask

    task automatic do_reset();
        btn_record_in = 1'b0;
        btn_play_in   = 1'b0;
        rst_n_in      = 1'b0;
        step();
        step();
        rst_n_in = 1'b1;
        model_reset();
    endtask

    task automatic pulse(input bit rec, input bit play);
        btn_record_in = rec;
        btn_play_in   = play;
        step();
        btn_record_in = 1'b0;
        btn_play_in   = 1'b0;
    endtask

    typedef struct {
        bit rec;
        bit play;
        int st;
        bit act;
        int len;
    } vec_t;

    task automatic run_table();
        vec_t tbl[17];
        tbl[0]  = '{0, 1, 0, 0, 0};
        tbl[1]  = '{1, 1, 2, 1, 0};
        tbl[2]  = '{0, 0, 2, 1, 0};
        tbl[3]  = '{1, 0, 3, 0, 0};
        tbl[4]  = '{0, 1, 3, 0, 0};
        tbl[5]  = '{1, 0, 2, 1, 0};
        tbl[6]  = '{0, 0, 2, 1, 0};
        tbl[7]  = '{0, 0, 2, 1, 0};
        tbl[8]  = '{0, 0, 2, 1, 0};
        tbl[9]  = '{0, 0, 2, 1, 0};
        tbl[10] = '{1, 0, 3, 0, 1};
        tbl[11] = '{0, 1, 4, 0, 1};
        tbl[12] = '{0, 0, 4, 0, 1};
        tbl[13] = '{0, 0, 4, 0, 1};
        tbl[14] = '{0, 0, 4, 0, 1};
        tbl[15] = '{0, 0, 3, 0, 1};
        tbl[16] = '{1, 1, 2, 1, 1};
        tick_period_in = 26'd4;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            pulse(tbl[i].rec, tbl[i].play);
            chk($sformatf("tbl%0d_state", i), state_out, tbl[i].st);
            chk($sformatf("tbl%0d_rec_act", i), record_active_out, tbl[i].act);
            chk($sformatf("tbl%0d_len", i), recorded_len_out, tbl[i].len);
        end
    endtask

    task automatic run_full_record();
        int nt, last, bad, cyc;
        tick_period_in = 26'd4;
        do_reset();
        pulse(1, 0);
        chk("full_rec_act_rise", record_active_out, 1);
        chk("full_state_rec", state_out, 2);
        nt = 0; last = -1; bad = 0; cyc = 0;
        while (nt < SLOTS && cyc < 1000) begin
            if (tick_out) begin
                if (last < 0 && cyc != 3) bad++;
                if (last >= 0 && cyc - last != 4) bad++;
                last = cyc;
                nt++;
            end
            step();
            cyc++;
        end
        chk("full_tick_count", nt, SLOTS);
        chk("full_tick_spacing", bad, 0);
        chk("full_state_done", state_out, 3);
        chk("full_len", recorded_len_out, SLOTS);
        chk("full_rec_act_fall", record_active_out, 0);
    endtask

    task automatic run_short_and_play();
        int nt, cyc;
        tick_period_in = 26'd4;
        do_reset();
        pulse(1, 0);
        nt = 0; cyc = 0;
        while (nt < 5 && cyc < 100) begin
            if (tick_out) nt++;
            step();
            cyc++;
        end
        chk("short_ticks", nt, 5);
        pulse(1, 0);
        chk("short_state_done", state_out, 3);
        chk("short_len", recorded_len_out, 5);
        chk("short_play_valid_done", play_valid_out, 0);
        pulse(0, 1);
        chk("short_state_pb", state_out, 4);
        chk("short_play_valid", play_valid_out, 1);
        for (int k = 0; k < 5; k++) begin
            cyc = 0;
            while (!tick_out && cyc < 20) begin
                step();
                cyc++;
            end
            chk($sformatf("pb_tick_wait%0d", k), (cyc < 20) ? 1 : 0, 1);
            chk($sformatf("pb_slot%0d", k), slot_idx_out, k);
            chk($sformatf("pb_note%0d", k), play_note_out, notes_in[k]);
            step();
        end
        chk("pb_end_state", state_out, 3);
        chk("pb_end_note", play_note_out, 0);
    endtask

    task automatic run_async_reset();
        pulse(1, 0);
        for (int i = 0; i < 6; i++) step();
        chk("arst_pre_state", state_out, CI_EN ? 1 : 2);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("arst_state", state_out, 0);
        chk("arst_rec_act", record_active_out, 0);
        chk("arst_len", recorded_len_out, 0);
        chk("arst_slot", slot_idx_out, 0);
        chk("arst_tick", tick_out, 0);
        chk("arst_valid", play_valid_out, 0);
        chk("arst_note", play_note_out, 0);
        step();
        rst_n_in = 1'b1;
        step();
        chk("arst_after_state", state_out, 0);
        model_reset();
    endtask

    task automatic run_default_period();
        int n;
        tick_period_in = 26'd0;
        do_reset();
        pulse(1, 0);
        n = 1;
        while (!tick_out && n < 100) begin
            step();
            n++;
        end
        chk("default_period_first_tick", n, CI_EN ? DEF_P : DEF_P);
    endtask

`ifdef COUNT_IN_EN
    task automatic run_count_in();
        int cyc, clicks, last_click, rise, n;
        tick_period_in = 26'd4;
        do_reset();
        pulse(1, 0);
        chk("ci_state", state_out, 1);
        cyc = 0; clicks = 0; last_click = -1; rise = -1;
        while (cyc < 200 && rise < 0) begin
            if (record_active_out) begin
                rise = cyc;
            end else begin
                if (click_out) begin
                    clicks++;
                    last_click = cyc;
                end
                step();
                cyc++;
            end
        end
        chk("ci_clicks", clicks, CI_TKS);
        chk("ci_rise_after_last", rise, last_click + 1);
        n = 0;
        while (!tick_out && n < 20) begin
            step();
            n++;
        end
        chk("ci_tick_no_gap", n, 3);
    endtask
`endif

    task automatic run_random(input int cycles);
        bit r, p;
        int pin;
        tick_period_in = 26'd3;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            chk("rnd_state", state_out, m_mode);
            chk("rnd_rec_act", record_active_out, (m_mode == 2) ? 1 : 0);
            chk("rnd_valid", play_valid_out, (m_mode == 4) ? 1 : 0);
            chk("rnd_tick", tick_out, model_tick());
            chk("rnd_click", click_out, (m_mode == 1 && model_tick()) ? 1 : 0);
            chk("rnd_len", recorded_len_out, m_len);
            chk("rnd_note", play_note_out,
                (m_mode == 4 && m_prev_mode == 4) ? notes_in[m_prev_slot] : 0);
            if (m_mode == 2 || m_mode == 4) chk("rnd_slot", slot_idx_out, model_slot());
            if ($urandom_range(0, 49) == 0) tick_period_in = 26'($urandom_range(0, 5));
            r = ($urandom_range(0, 29) == 0);
            p = ($urandom_range(0, 14) == 0);
            pin = int'(tick_period_in);
            model_step(r, p, pin);
            btn_record_in = r;
            btn_play_in   = p;
            step();
            btn_record_in = 1'b0;
            btn_play_in   = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < SLOTS; i++) notes_in[i] = 6'($urandom_range(1, 63));
        do_reset();
        chk("reset_state", state_out, 0);
        chk("reset_rec_act", record_active_out, 0);
        chk("reset_len", recorded_len_out, 0);
        chk("reset_tick", tick_out, 0);
        chk("reset_note", play_note_out, 0);
        chk("reset_click", click_out, 0);
`ifndef COUNT_IN_EN
        run_table();
        run_full_record();
        run_short_and_play();
        run_async_reset();
        run_default_period();
`else
        run_count_in();
        run_async_reset();
`endif
        run_random(4000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/record_sequencer.md
# record_sequencer

Session controller for the note transcription path. It sequences a recording session by generating the record enable and the eighth-note tick that time the note writer, and tracks the recorded length. It then plays the captured note array back one slot per tick for display and audio. It sits between the debounced user buttons and the note writer / note array, and is the only block that asserts the writer's toggle input.

## Interface
Parameters:
- SLOTS, 160, number of note slots per session (max 255)
- DEFAULT_PERIOD, 34816000, eighth-note period in clk cycles, used when tick_period_in is 0
- COUNT_IN_TICKS, 8, ticks of count-in before recording (used only with COUNT_IN_EN)

Ports:
- clk_in  input  1  system clock; all logic is single-clock
- rst_n_in  input  1  asynchronous, active-low reset
- btn_record_in  input  1  single-cycle pulse: start or stop recording
- btn_play_in  input  1  single-cycle pulse: start or stop playback
- tick_period_in  input  26  eighth-note period in cycles, sampled at session start
- notes_in  input  SLOTS x 6  recorded note array from the writer
- record_active_out  output  1  drives the writer's toggle input
- tick_out  output  1  one-cycle pulse per eighth note
- slot_idx_out  output  8  current slot during record or playback
- recorded_len_out  output  8  slots captured in the last session
- play_note_out  output  6  note for the current playback slot
- play_valid_out  output  1  high while play_note_out is meaningful
- click_out  output  1  count-in click pulse (0 when COUNT_IN_EN is absent)
- state_out  output  3  encoded state: IDLE=0, COUNT_IN=1, RECORD=2, DONE=3, PLAYBACK=4

## Operation
- All registered outputs reset to 0 and the state resets to IDLE while rst_n_in=0, asynchronously. Reset mid-session aborts immediately and recorded_len_out returns to 0.
- Tick generator:
  - A 26-bit counter runs only in COUNT_IN, RECORD and PLAYBACK.
  - tick_out=1 for the cycle in which counter==period-1; the counter then wraps to 0.
  - period is latched on entry to COUNT_IN, RECORD or PLAYBACK. A value of 0 selects DEFAULT_PERIOD. Later changes to tick_period_in take effect only at the next session.
- IDLE:
  - btn_record -> COUNT_IN (macro defined) or RECORD. The counter and slot_idx clear to 0.
  - btn_play is ignored when recorded_len==0; otherwise it moves to PLAYBACK.
- COUNT_IN: click_out pulses with each tick. After COUNT_IN_TICKS ticks -> RECORD. btn_record aborts to IDLE.
- RECORD:
  - record_active_out=1.
  - Each tick increments slot_idx.
  - On the tick that brings slot_idx to SLOTS -> DONE, with recorded_len=SLOTS.
  - btn_record -> DONE, with recorded_len=slot_idx (can be 0).
- DONE: record_active_out=0. btn_record starts a new session as from IDLE. btn_play with recorded_len>0 -> PLAYBACK, with slot_idx=0.
- PLAYBACK:
  - play_valid_out=1.
  - Each tick increments slot_idx.
  - On the tick where slot_idx==recorded_len-1 -> DONE.
  - btn_play -> DONE.
  - btn_record stops playback and starts a new recording.
- btn_record and btn_play in the same cycle: record wins, and play is ignored.
- slot_idx never exceeds SLOTS-1 while being used to index notes_in.

## Timing
- State changes and record_active_out take effect on the clock edge after the button pulse (1-cycle latency).
- The first tick arrives period cycles after entering a ticking state.
- play_note_out is registered as notes_in[slot_idx_out], so it lags slot_idx_out by 1 cycle. play_note_out is 0 when not in PLAYBACK.
- slot_idx_out updates on the cycle after the tick pulse.
- The writer samples while record_active_out=1. Dropping record_active_out for one cycle between sessions resets the writer.

## Configuration
- COUNT_IN_EN defined:
  - The COUNT_IN state exists.
  - Recording begins COUNT_IN_TICKS ticks after btn_record.
  - click_out pulses on each count-in tick.
- COUNT_IN_EN undefined:
  - btn_record goes directly to RECORD.
  - click_out is tied to 0.
  - State encoding 1 is unused.

## Test plan
- Reset with rst_n_in=0 mid-RECORD (period 4) -> all outputs 0 and state_out=0 immediately, with no clock edge needed; after release, IDLE.
- Period 4, no macro, btn_record -> record_active_out=1 next cycle; ticks every 4 cycles; after 160 ticks state_out=3, recorded_len_out=160, record_active_out=0.
- Period 4, btn_record, then btn_record after 5 ticks -> DONE, recorded_len_out=5; btn_play -> play_note_out steps through notes_in[0..4], then DONE after the 5th tick.
- Period 0 -> the first tick arrives DEFAULT_PERIOD cycles after entering RECORD.
- btn_play in IDLE with recorded_len=0 -> no state change. btn_record and btn_play pulsed in the same cycle -> RECORD.
- With COUNT_IN_EN and period 4 -> 8 click_out pulses, record_active_out rises on the cycle after the 8th tick, and tick_out continues without a gap.
